// File: rtl/adder_share_ctrl.sv
// Byte-serial wide adder sequencer: round-robin picks one requester, then streams
// its operands LSB-first through one shared registered 8-bit adder, chaining carry.
module adder_share_ctrl #(
  parameter int NREQ   = 4,
  parameter int NBYTES = 4,
  localparam int W     = 8*NBYTES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W-1:0]    op_a,
  input  logic [NREQ*W-1:0]    op_b,
  input  logic [NREQ-1:0]      op_cin,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           done_id,
  output logic [W-1:0]         result,
  output logic                 cout,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_cin,
  input  logic [7:0]           add_sum,
  input  logic                 add_cout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

  state_t                  r_state, w_nxt;
  logic [PW-1:0]           r_ptr, r_own, w_sel;
  logic                    w_sel_vld;
  logic [IW-1:0]           r_idx;
  logic                    r_carry, r_cout;
  logic [NBYTES-1:0][7:0]  r_a, r_b, r_res;
  logic [2:0]              r_done_id;
  logic [NREQ-1:0][W-1:0]  w_opa, w_opb;
  logic                    w_last;

  assign w_opa  = op_a;
  assign w_opb  = op_b;
  assign w_last = (r_idx == IW'(NBYTES-1));

  assign result  = r_res;
  assign cout    = r_cout;
  assign done_id = r_done_id;

  // Descending scan so the nearest requester after the pointer wins.
  always_comb begin : p_arb
    logic [PW-1:0] j;
    w_sel_vld = 1'b0;
    w_sel     = r_ptr;
    j         = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = PW'((int'(r_ptr) + k) % NREQ);
      if (req[j]) begin
        w_sel_vld = 1'b1;
        w_sel     = j;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    gnt     = '0;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    busy    = (r_state != IDLE);
    done    = (r_state == DONE);
    case (r_state)
      IDLE:  if (w_sel_vld) w_nxt = ISSUE;
      ISSUE: begin
        add_a   = r_a[r_idx];
        add_b   = r_b[r_idx];
        add_cin = r_carry;
        if (r_idx == '0) gnt[r_own] = 1'b1;
        w_nxt   = CAPT;
      end
      CAPT:  w_nxt = w_last ? DONE : ISSUE;
      DONE:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= PW'(NREQ-1);
      r_own     <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_done_id <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_sel_vld) begin
          r_a     <= w_opa[w_sel];
          r_b     <= w_opb[w_sel];
          r_carry <= op_cin[w_sel];
          r_own   <= w_sel;
          r_ptr   <= w_sel;
          r_idx   <= '0;
        end
        // Adder output here belongs to the byte issued in the previous cycle.
        CAPT: begin
          r_res[r_idx] <= add_sum;
          r_carry      <= add_cout;
          if (w_last) begin
            r_cout    <= add_cout;
            r_done_id <= 3'(r_own);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl with a behavioural registered 8-bit adder.
module tb_adder_share_ctrl;
  localparam int NREQ = 4, NBYTES = 4, W = 32;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0, op_cin = '0;
  logic [NREQ*W-1:0] op_a = '0, op_b = '0;
  logic [NREQ-1:0]   gnt;
  logic              busy, done, cout, add_cin, add_cout;
  logic [2:0]        done_id;
  logic [W-1:0]      result;
  logic [7:0]        add_a, add_b, add_sum;

  adder_share_ctrl #(.NREQ(NREQ), .NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .result(result), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);

  typedef struct { logic [2:0] id; logic [W-1:0] res; logic co; } exp_t;
  exp_t done_q[$];
  int   gnt_q[$];
  int   n_vec = 0, n_err = 0, cyc = 0, last_gnt = -1, n_gnt = 0;
  bit   spc_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t x;
    logic [NREQ-1:0] g1;
    int e;
    if (rst_n && gnt != '0) begin
      chk("gnt_onehot", 64'($countones(gnt)), 64'd1);
      if (gnt_q.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'd0);
      else begin
        e = gnt_q.pop_front();
        g1 = '0;
        g1[e] = 1'b1;
        chk("gnt_id", 64'(gnt), 64'(g1));
      end
      if (spc_chk && last_gnt >= 0) chk("gnt_spacing", 64'(cyc - last_gnt), 64'd10);
      last_gnt <= cyc;
      n_gnt    <= n_gnt + 1;
    end
    if (rst_n && done) begin
      if (done_q.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
      else begin
        x = done_q.pop_front();
        chk("done_id", 64'(done_id), 64'(x.id));
        chk("result", 64'(result), 64'(x.res));
        chk("cout", 64'(cout), 64'(x.co));
      end
    end
  end

  task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    op_a[id*W +: W] = a;
    op_b[id*W +: W] = b;
    op_cin[id]      = ci;
  endtask

  task automatic push_exp(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    done_q.push_back('{3'(id), s[W-1:0], s[W]});
    gnt_q.push_back(id);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_done_id"}, 64'(done_id), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_cout"}, 64'(cout), 64'd0);
    chk({tag, "_add"}, 64'({add_a, add_b, add_cin}), 64'd0);
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (gnt != '0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_cnt(input int target, input int lim);
    bit ok = 1'b0;
    for (int t = 0; t < lim; t++) begin
      @(negedge clk);
      if (n_gnt >= target) begin ok = 1'b1; break; end
    end
    if (!ok) chk("grant_count_timeout", 64'(n_gnt), 64'(target));
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 64'(done_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Single request: checks adder port traffic, latency and done pulse shape.
  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    bit ok;
    logic c;
    logic [8:0] s9;
    logic [W:0] full;
    set_op(id, a, b, ci);
    push_exp(id, a, b, ci);
    req[id] = 1'b1;
    wait_gnt(ok);
    req[id] = 1'b0;
    if (!ok) return;
    c = ci;
    for (int k = 0; k < NBYTES; k++) begin
      chk("issue_add_a", 64'(add_a), 64'(a[k*8 +: 8]));
      chk("issue_add_b", 64'(add_b), 64'(b[k*8 +: 8]));
      chk("issue_add_cin", 64'(add_cin), 64'(c));
      s9 = {1'b0, a[k*8 +: 8]} + {1'b0, b[k*8 +: 8]} + 9'(c);
      c  = s9[8];
      @(negedge clk);
      chk("capt_add_zero", 64'({add_a, add_b, add_cin}), 64'd0);
      chk("capt_busy", 64'(busy), 64'd1);
      chk("capt_no_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    chk("done_latency", 64'(done), 64'd1);
    @(negedge clk);
    full = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("result_hold", 64'(result), 64'(full[W-1:0]));
  endtask

  initial begin
    bit ok;
    int base;
    #2 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    run_op(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    run_op(1, 32'h8000_0000, 32'h8000_0001, 1'b0);
    run_op(3, $urandom, $urandom, 1'($urandom_range(1)));

    // Reset in the third CAPT cycle: op discarded, no done expected.
    set_op(1, 32'h0102_0304, 32'h1020_3040, 1'b1);
    gnt_q.push_back(1);
    req[1] = 1'b1;
    wait_gnt(ok);
    req[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("midop_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1 check_zero("midop_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op(1, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 1'b1);

    // Contention from reset: rotation 0,1,2,3,0 at 10-cycle spacing.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      set_op(i, 32'h1111_0000 * (i + 1) + 32'h00FF_00F0, 32'hF00F_1234 + 32'(i), 1'(i));
    for (int i = 0; i < 5; i++)
      push_exp(i % NREQ, op_a[(i % NREQ)*W +: W], op_b[(i % NREQ)*W +: W], op_cin[i % NREQ]);
    base = n_gnt;
    last_gnt = -1;
    spc_chk = 1'b1;
    req = 4'b1111;
    wait_cnt(base + 5, 80);
    req = '0;
    drain();

    // Fairness with 0 and 2 held; pointer sits at 0 so expect 2,0,2.
    set_op(0, 32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
    set_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    push_exp(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    push_exp(0, 32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
    push_exp(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    base = n_gnt;
    last_gnt = -1;
    req = 4'b0101;
    wait_cnt(base + 3, 60);
    req = '0;
    drain();
    spc_chk = 1'b0;

    chk("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
